// File: rtl/hbridge_if.sv
// Signal bundle between the PWM stages and the H-bridge gate driver.
// The master side supplies enable and PWM. The slave side returns the gate drives and status.
interface hbridge_if;
  logic en;
  logic pwm_r;
  logic pwm_l;
  logic hs_a;
  logic ls_a;
  logic hs_b;
  logic ls_b;
  logic dir;
  logic fault;

  modport master (
    output en, pwm_r, pwm_l,
    input  hs_a, ls_a, hs_b, ls_b, dir, fault
  );

  modport slave (
    input  en, pwm_r, pwm_l,
    output hs_a, ls_a, hs_b, ls_b, dir, fault
  );
endinterface

// File: rtl/hbridge_driver.sv
// H-bridge gate driver: dead-time on leg transitions, coast on reversal,
// sticky fault when both PWM inputs are high together.
module hbridge_driver #(
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned REV_HOLD    = 8
) (
  input logic     clk,
  input logic     rst,
  hbridge_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FWD, REV, COAST, FAULT} state_t;

  localparam logic [7:0] DEAD_LD = 8'(DEAD_CYCLES);
  localparam logic [7:0] HOLD_LD = 8'(REV_HOLD);

  state_t     state_q, state_d;
  logic       hs_a_q, hs_a_d, ls_a_q, ls_a_d;
  logic       hs_b_q, hs_b_d, ls_b_q, ls_b_d;
  logic       dir_q, dir_d, fault_q, fault_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tgt_q, tgt_d;    // coast target: 1 = REV
  logic       last_q, last_d;  // last accepted level of the tracked PWM input

  always_comb begin
    state_d = state_q;
    hs_a_d  = hs_a_q;
    ls_a_d  = ls_a_q;
    hs_b_d  = hs_b_q;
    ls_b_d  = ls_b_q;
    dir_d   = dir_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    last_d  = last_q;

    if (state_q != FAULT && bus.en && bus.pwm_r && bus.pwm_l) begin
      state_d = FAULT;
      {hs_a_d, ls_a_d, hs_b_d, ls_b_d} = '0;
      fault_d = 1'b1;
      cnt_d   = '0;
    end else if (state_q != FAULT && !bus.en) begin
      state_d = IDLE;
      {hs_a_d, ls_a_d, hs_b_d, ls_b_d} = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          {hs_a_d, ls_a_d, hs_b_d, ls_b_d} = '0;
          if (bus.pwm_r) begin
            state_d = FWD;
            ls_b_d  = 1'b1;
            dir_d   = 1'b0;
            cnt_d   = DEAD_LD;
            last_d  = 1'b1;
          end else if (bus.pwm_l) begin
            state_d = REV;
            ls_a_d  = 1'b1;
            dir_d   = 1'b1;
            cnt_d   = DEAD_LD;
            last_d  = 1'b1;
          end
        end
        FWD: begin
          if (bus.pwm_l && !bus.pwm_r) begin
            state_d = COAST;
            {hs_a_d, ls_a_d, hs_b_d, ls_b_d} = '0;
            cnt_d   = HOLD_LD;
            tgt_d   = 1'b1;
          end else if (bus.pwm_r != last_q) begin
            // Any change, including one inside a dead window, restarts the window with leg A off.
            hs_a_d = 1'b0;
            ls_a_d = 1'b0;
            cnt_d  = DEAD_LD;
            last_d = bus.pwm_r;
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              hs_a_d = bus.pwm_r;
              ls_a_d = ~bus.pwm_r;
            end
          end
        end
        REV: begin
          if (bus.pwm_r && !bus.pwm_l) begin
            state_d = COAST;
            {hs_a_d, ls_a_d, hs_b_d, ls_b_d} = '0;
            cnt_d   = HOLD_LD;
            tgt_d   = 1'b0;
          end else if (bus.pwm_l != last_q) begin
            hs_b_d = 1'b0;
            ls_b_d = 1'b0;
            cnt_d  = DEAD_LD;
            last_d = bus.pwm_l;
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              hs_b_d = bus.pwm_l;
              ls_b_d = ~bus.pwm_l;
            end
          end
        end
        COAST: begin
          if (cnt_q > 8'd1) begin
            cnt_d = cnt_q - 8'd1;
          end else begin
            // Coast already covers the dead window, so the switching leg goes straight to its PWM level.
            cnt_d = '0;
            if (tgt_q) begin
              state_d = REV;
              hs_a_d  = 1'b0;
              ls_a_d  = 1'b1;
              hs_b_d  = bus.pwm_l;
              ls_b_d  = ~bus.pwm_l;
              dir_d   = 1'b1;
              last_d  = bus.pwm_l;
            end else begin
              state_d = FWD;
              hs_a_d  = bus.pwm_r;
              ls_a_d  = ~bus.pwm_r;
              hs_b_d  = 1'b0;
              ls_b_d  = 1'b1;
              dir_d   = 1'b0;
              last_d  = bus.pwm_r;
            end
          end
        end
        FAULT: begin
          {hs_a_d, ls_a_d, hs_b_d, ls_b_d} = '0;
          fault_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
          {hs_a_d, ls_a_d, hs_b_d, ls_b_d} = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hs_a_q  <= 1'b0;
      ls_a_q  <= 1'b0;
      hs_b_q  <= 1'b0;
      ls_b_q  <= 1'b0;
      dir_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_a_q  <= hs_a_d;
      ls_a_q  <= ls_a_d;
      hs_b_q  <= hs_b_d;
      ls_b_q  <= ls_b_d;
      dir_q   <= dir_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      last_q  <= last_d;
    end
  end

  assign bus.hs_a  = hs_a_q;
  assign bus.ls_a  = ls_a_q;
  assign bus.hs_b  = hs_b_q;
  assign bus.ls_b  = ls_b_q;
  assign bus.dir   = dir_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_hbridge_driver.sv
// Bench for hbridge_driver: a table of {rst,en,pwm_r,pwm_l} / {hs_a,ls_a,hs_b,ls_b,dir,fault}
// rows drives a scoreboard queue, with a per-cycle invariant check and a hand-timed reversal.
module tb_hbridge_driver;

  logic clk = 1'b0;
  logic rst;
  int unsigned total = 0;
  int unsigned bad   = 0;

  hbridge_if bus ();

  hbridge_driver #(.DEAD_CYCLES(2), .REV_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    int         idx;
    logic [5:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  exp_q[$];

  task automatic v(input int unsigned n, input logic [3:0] in, input logic [5:0] exp);
    vec_t t;
    t.in  = in;
    t.exp = exp;
    repeat (n) vecs.push_back(t);
  endtask

  // Monitor: invariants every cycle, scoreboard pop when a row's edge has passed.
  always @(posedge clk) begin
    logic [5:0] got;
    sb_t        s;
    #1;
    got = {bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b, bus.dir, bus.fault};
    total++;
    if ((bus.hs_a && bus.ls_a) || (bus.hs_b && bus.ls_b) || (bus.hs_a && bus.hs_b) ||
        (bus.fault && (bus.hs_a || bus.ls_a || bus.hs_b || bus.ls_b))) begin
      bad++;
      $display("FAIL invariant t=%0t got=%b want=no overlap and gates off in fault", $time, got);
    end
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      total++;
      if (got !== s.exp) begin
        bad++;
        $display("FAIL row%0d got=%b want=%b", s.idx, got, s.exp);
      end
    end
  end

  task automatic drive(input logic [3:0] in);
    @(negedge clk);
    {rst, bus.en, bus.pwm_r, bus.pwm_l} = in;
  endtask

  initial begin
    int unsigned zeros;
    int unsigned guard;
    rst = 1'b1; bus.en = 1'b0; bus.pwm_r = 1'b0; bus.pwm_l = 1'b0;

    // reset, then forward start with DEAD=2 on-delay
    v(2, 4'b1000, 6'b000000);
    v(1, 4'b0100, 6'b000000);
    v(2, 4'b0110, 6'b000100);
    v(2, 4'b0110, 6'b100100);
    // pwm_r fall and rise: off at sampled edge, other device two edges later
    v(2, 4'b0100, 6'b000100);
    v(2, 4'b0100, 6'b010100);
    v(2, 4'b0110, 6'b000100);
    v(2, 4'b0110, 6'b100100);
    // one-cycle low glitch: ls_a never asserts
    v(1, 4'b0100, 6'b000100);
    v(2, 4'b0110, 6'b000100);
    v(1, 4'b0110, 6'b100100);
    // FWD -> REV reversal: 8 cycles all off, then REV driving hs_b
    v(8, 4'b0101, 6'b000000);
    v(2, 4'b0101, 6'b011010);
    // REV pwm_l fall: low-side braking on leg B
    v(2, 4'b0100, 6'b010010);
    v(1, 4'b0100, 6'b010110);
    // fault: sticky through en toggles, cleared by rst
    v(1, 4'b0111, 6'b000011);
    v(1, 4'b0100, 6'b000011);
    v(1, 4'b0000, 6'b000011);
    v(1, 4'b0110, 6'b000011);
    v(1, 4'b1000, 6'b000000);
    v(1, 4'b0100, 6'b000000);
    // en=0 in COAST (counter=5), re-enable with pwm_l into REV with dead-time
    v(2, 4'b0110, 6'b000100);
    v(1, 4'b0110, 6'b100100);
    v(4, 4'b0101, 6'b000000);
    v(2, 4'b0001, 6'b000000);
    v(2, 4'b0101, 6'b010010);
    v(1, 4'b0101, 6'b011010);
    // REV -> FWD reversal, dir updates on coast exit
    v(8, 4'b0110, 6'b000010);
    v(1, 4'b0110, 6'b100100);
    // rst in the middle of a dead window
    v(1, 4'b0100, 6'b000100);
    v(1, 4'b1100, 6'b000000);
    v(1, 4'b0100, 6'b000000);
    v(1, 4'b0110, 6'b000100);

    foreach (vecs[i]) begin
      sb_t s;
      drive(vecs[i].in);
      s.idx = i;
      s.exp = vecs[i].exp;
      exp_q.push_back(s);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end

    // Hand-timed reversal: count all-off cycles directly.
    repeat (3) drive(4'b0110);
    @(posedge clk); #1;
    total++;
    if (bus.hs_a !== 1'b1) begin
      bad++;
      $display("FAIL pre_rev_hs_a got=%b want=1", bus.hs_a);
    end
    drive(4'b0101);
    zeros = 0;
    guard = 0;
    while (guard < 40) begin
      @(posedge clk); #1;
      guard++;
      if ({bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b} == 4'b0000) zeros++;
      else break;
    end
    total++;
    if (zeros != 8) begin
      bad++;
      $display("FAIL coast_len got=%0d want=8", zeros);
    end
    total++;
    if ({bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b, bus.dir} !== 5'b01101) begin
      bad++;
      $display("FAIL rev_entry got=%b want=01101",
               {bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b, bus.dir});
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
